// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button front end: the per-key FSM state
// encoding, board timing constants (50 MHz) and reduced simulation timings.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while a key is held).
package key_pkg;

    // Per-key filter state. UP/DOWN are the accepted levels; the *_PEND
    // states count stable cycles before accepting a change.
    typedef enum logic [1:0] {
        UP        = 2'd0,
        DOWN_PEND = 2'd1,
        DOWN      = 2'd2,
        UP_PEND   = 2'd3
    } key_state_t;

    // Board defaults: 10 ms debounce, 0.5 s first repeat, 0.2 s repeat rate.
    localparam int DEF_N_KEYS          = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_CNT_W           = 20;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    // Short timings so simulation finishes in a few hundred cycles.
    localparam int SIM_DEBOUNCE_CYCLES = 8;
    localparam int SIM_REPEAT_DELAY    = 40;
    localparam int SIM_REPEAT_PERIOD   = 16;

    // Width of a counter that must reach max(delay, period) - 1.
    function automatic int rep_cnt_w(input int delay, input int period);
        int max_v;
        max_v = (delay > period) ? delay : period;
        return (max_v < 2) ? 1 : $clog2(max_v);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Signal bundle between the raw buttons and the debounced consumers.
// There is no valid/ready handshake on this bundle: key_n is a level sampled
// on every clock, key_db_n is a registered level, and press_pulse is a
// one-cycle fire-and-forget strobe with no backpressure (a consumer that is
// not looking in that cycle misses it).
interface key_debounce_if
    import key_pkg::*;
#(
    parameter int N_KEYS = DEF_N_KEYS
) ();

    logic [N_KEYS-1:0] key_n;        // raw buttons, 0 = pressed
    logic [N_KEYS-1:0] key_db_n;     // debounced level, 0 = pressed
    logic [N_KEYS-1:0] press_pulse;  // one-cycle strobe per accepted press

    modport master (
        output key_n,
        input  key_db_n,
        input  press_pulse
    );

    modport slave (
        input  key_n,
        output key_db_n,
        output press_pulse
    );

endinterface

// File: rtl/key_debounce_ch.sv
// One key: two-flop synchronizer, debounce FSM with stable-cycle counter,
// registered level and press strobe. With KEY_REPEAT_EN defined, a held key
// also emits periodic repeat strobes, each paired with a one-cycle high blip
// on the level so falling-edge consumers advance once per repeat.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_key_n,
    output logic       o_key_db_n,
    output logic       o_press_pulse,
    output key_state_t o_state
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The counter is compared against DEBOUNCE_CYCLES-1, so it must fit.
    if (DEBOUNCE_CYCLES < 2 || ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cfg
        $error("key_debounce_ch: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    logic             r_s1;
    logic             r_s2;
    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_key_db_n;
    logic             r_press_pulse;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = rep_cnt_w(REPEAT_DELAY, REPEAT_PERIOD);

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
        $error("key_debounce_ch: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_first;  // still waiting for the first (longer) delay
    logic [REP_W-1:0] w_rep_last;

    assign w_rep_last = r_rep_first ? REP_W'(REPEAT_DELAY - 1)
                                    : REP_W'(REPEAT_PERIOD - 1);
`endif

    // Two-flop synchronizer; idles high so reset looks like "not pressed".
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_key_n;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM: accept a level only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= UP;
            r_cnt         <= '0;
            r_key_db_n    <= 1'b1;
            r_press_pulse <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rep_cnt     <= '0;
            r_rep_first   <= 1'b1;
`endif
        end else begin
            r_press_pulse <= 1'b0;
            case (r_state)
                UP: begin
                    if (!r_s2) begin
                        r_state <= DOWN_PEND;
                        r_cnt   <= CNT_ONE;
                    end
                end
                DOWN_PEND: begin
                    if (r_s2) begin
                        r_state <= UP;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= DOWN;
                        r_cnt         <= '0;
                        r_key_db_n    <= 1'b0;
                        r_press_pulse <= 1'b1;
`ifdef KEY_REPEAT_EN
                        r_rep_cnt     <= '0;
                        r_rep_first   <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (r_s2) begin
                        r_state    <= UP_PEND;
                        r_cnt      <= CNT_ONE;
                        // Closes any repeat blip so the level is "pressed"
                        // until the release is accepted.
                        r_key_db_n <= 1'b0;
`ifdef KEY_REPEAT_EN
                        r_rep_cnt   <= '0;
                        r_rep_first <= 1'b1;
                    end else if (r_rep_cnt == w_rep_last) begin
                        r_key_db_n    <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_rep_cnt     <= '0;
                        r_rep_first   <= 1'b0;
                    end else begin
                        r_key_db_n <= 1'b0;
                        r_rep_cnt  <= r_rep_cnt + 1'b1;
`endif
                    end
                end
                UP_PEND: begin
                    if (!r_s2) begin
                        r_state <= DOWN;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= UP;
                        r_cnt      <= '0;
                        r_key_db_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= UP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_key_db_n    = r_key_db_n;
    assign o_press_pulse = r_press_pulse;
    assign o_state       = r_state;

endmodule

// File: rtl/key_debounce.sv
// Push-button front end: N_KEYS independent debounce channels. Produces a
// clean active-low level per key (for the digit counters' falling-edge
// inputs) and a one-cycle press strobe per key. o_dbg_state exposes every
// channel's FSM state, two bits per key, key 0 in the low bits.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while held).
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = DEF_N_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    key_debounce_if.slave         bus,
    output logic [2*N_KEYS-1:0]   o_dbg_state
);

    if (N_KEYS < 1) begin : g_bad_keys
        $error("key_debounce: N_KEYS must be >= 1");
    end

    logic [N_KEYS-1:0] w_key_db_n;
    logic [N_KEYS-1:0] w_press_pulse;
    key_state_t        w_state [N_KEYS];

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
`ifdef KEY_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .i_key_n       (bus.key_n[i]),
            .o_key_db_n    (w_key_db_n[i]),
            .o_press_pulse (w_press_pulse[i]),
            .o_state       (w_state[i])
        );

        assign o_dbg_state[2*i +: 2] = w_state[i];
    end

    assign bus.key_db_n    = w_key_db_n;
    assign bus.press_pulse = w_press_pulse;

endmodule
